// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared definitions for the sequential shift-add multiplier:
//               FSM state encoding and the iteration-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // FSM state encoding, explicit 2-bit width.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Iteration counter width for an N-iteration multiply: clog2(N),
    // never less than one bit so the counter always exists.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Counter width for the default configuration (N = 4).
    localparam int c_default_cnt_w = cnt_width(4);

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_addsub.sv
`default_nettype none
// ============================================================================
// Module      : mult_addsub
// Description : W-bit adder/subtractor used by the multiplier datapath.
//               Result wraps modulo 2**W; the caller sizes W so the
//               partial-product sum never overflows.
// Ports       : i_a   [W-1:0]  minuend / first addend (accumulator)
//               i_b   [W-1:0]  subtrahend / second addend (multiplicand)
//               i_sub          1 = i_a - i_b, 0 = i_a + i_b
//               o_y   [W-1:0]  result
// Revision    : 1.0 - initial release
// ============================================================================
module mult_addsub #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_y
);

    assign o_y = i_sub ? (i_a - i_b) : (i_a + i_b);

endmodule : mult_addsub
`default_nettype wire

// File: rtl/seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_add_multiplier
// Description : Sequential shift-and-add multiplier, one multiplier bit per
//               clock, unsigned or two's-complement operands. Fixed latency
//               of N clocks from the accepted start to the done pulse.
// Ports       : clk          clock, rising-edge
//               rst          asynchronous reset, active low
//               start        begin a multiply (accepted in IDLE or DONE)
//               signed_mode  1 = two's complement, 0 = unsigned
//               a   [M-1:0]  multiplicand
//               b   [N-1:0]  multiplier
//               busy         high while iterating
//               done         one-cycle pulse when product updates
//               product [M+N-1:0] result, held until the next done
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int M = 4,
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [M-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [M+N-1:0]   product
);

    localparam int                c_cnt_w = cnt_width(N);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(N - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [M:0]          r_acc;      // upper partial product, one guard bit
    logic [N-1:0]        r_mplier;   // multiplier, shifted out LSB-first
    logic [M-1:0]        r_mcand;
    logic                r_signed;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [M+N-1:0]      r_product;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [M:0]   w_mcand_ext;
    logic [M:0]   w_addend;
    logic         w_last;
    logic         w_sub;
    logic [M:0]   w_sum;
    logic         w_fill;
    logic [M:0]   w_acc_nxt;
    logic [N-1:0] w_mpl_nxt;

    // Guard bit: sign copy in signed mode, zero otherwise.
    assign w_mcand_ext = {r_signed & r_mcand[M-1], r_mcand};

    // A zero addend turns a "no add" iteration into acc + 0.
    assign w_addend = r_mplier[0] ? w_mcand_ext : '0;

    assign w_last = (r_cnt == c_last);

    // In two's complement the multiplier MSB carries weight -2**(N-1),
    // so its partial product is subtracted. On the last iteration the
    // register LSB holds that original MSB.
    assign w_sub = r_signed & w_last & r_mplier[0];

    mult_addsub #(
        .W (M + 1)
    ) u_addsub (
        .i_a   (r_acc),
        .i_b   (w_addend),
        .i_sub (w_sub),
        .o_y   (w_sum)
    );

    // Right shift of {sum, multiplier}: arithmetic when signed, logical
    // otherwise. Unsigned sums never exceed M+1 bits because the guard
    // bit is always zero after the previous shift.
    assign w_fill    = r_signed & w_sum[M];
    assign w_acc_nxt = {w_fill, w_sum[M:1]};
    assign w_mpl_nxt = {w_sum[0], r_mplier[N-1:1]};

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_mplier  <= '0;
            r_mcand   <= '0;
            r_signed  <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    // done is a single-cycle pulse; DONE always leaves.
                    r_done <= 1'b0;
                    if (start) begin
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_signed <= signed_mode;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    // start is deliberately ignored here.
                    r_acc    <= w_acc_nxt;
                    r_mplier <= w_mpl_nxt;
                    r_cnt    <= r_cnt + c_one;
                    if (w_last) begin
                        r_product <= {w_acc_nxt[M-1:0], w_mpl_nxt};
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_DONE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule : seq_shift_add_multiplier
`default_nettype wire

// File: doc/seq_shift_add_multiplier.md
SEQ_SHIFT_ADD_MULTIPLIER -- requirements
Module: seq_shift_add_multiplier

Interface
REQ-001 SHALL have parameter M, default 4, multiplicand width (M >= 2).
REQ-002 SHALL have parameter N, default 4, multiplier width and iteration count (N >= 2).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to begin a multiply, sampled on clk.
REQ-006 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 SHALL have port a  input  M  multiplicand, sampled with start.
REQ-008 SHALL have port b  input  N  multiplier, sampled with start.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when product becomes valid.
REQ-011 SHALL have port product  output  M+N  result, held until the next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; on acceptance latch a, b and signed_mode, clear the accumulator, load iteration counter 0, and enter RUN.
REQ-014 SHALL ignore start while in RUN; latched operands and mode stay unchanged.
REQ-015 SHALL perform exactly one iteration per clock in RUN: if the current multiplier LSB = 1, add the multiplicand to the upper (M+1)-bit accumulator; then shift the {accumulator, multiplier} register right by one.
REQ-016 SHALL, in unsigned mode, zero-extend the multiplicand to M+1 bits and use logical right shift.
REQ-017 SHALL, in signed mode, sign-extend the multiplicand to M+1 bits, use arithmetic right shift, and on the final iteration (counter = N-1) subtract instead of add when the multiplier MSB = 1.
REQ-018 SHALL have fixed latency: with start accepted on edge E0, RUN covers edges E1..EN, and product and done update on edge EN (N edges after E0); no early termination for zero operands.
REQ-019 SHALL, in DONE, assert done for exactly one cycle; busy = 0; then go to IDLE unless start is asserted in that cycle, in which case go directly to RUN (back-to-back operation, no bubble).
REQ-020 SHALL assert busy = 1 exactly while in RUN.
REQ-021 SHALL keep product unchanged from one done pulse until the done pulse of the next operation.
REQ-022 SHALL produce the exact M+N-bit result with no overflow, including signed most-negative x most-negative.

Reset
REQ-023 SHALL, on rst low at any time including mid-RUN, enter IDLE asynchronously with busy = 0, done = 0, product = 0, and the accumulator, counter and operand registers all 0.
REQ-024 SHALL take no start in the cycle in which rst deasserts; the first start can be accepted on the next rising edge after rst = 1.

Structure
REQ-025 SHALL place the FSM state enum and the counter-width helper constant (clog2 of N) in shared package mult_pkg.
REQ-026 SHALL isolate the (M+1)-bit add/subtract unit in a single sub-module, mult_addsub (inputs: operands and a sub flag), instantiated once.

Verification (M = N = 4)
REQ-027 Unsigned: a = 4'hF, b = 4'hF, start -> busy for 4 cycles, done pulse 4 edges after start, product = 8'hE1.
REQ-028 Signed: a = 4'b1000 (-8), b = 4'b0111 (7) -> product = 8'hC8; a = 7, b = -8 -> product = 8'hC8 (final-cycle subtract); a = -8, b = -8 -> product = 8'h40.
REQ-029 Back-to-back: unsigned 12 x 2 then start held in the DONE cycle with 3 x 3 -> first done with product = 8'h18, second done exactly 4 edges later with product = 8'h09.
REQ-030 Start while busy: new start at cycle 2 of RUN with a = 1, b = 1 -> ignored; product = result of the original operands.
REQ-031 Reset mid-operation: rst low during RUN cycle 2 -> outputs 0 immediately (asynchronous), no done pulse; a new start after release completes normally.
REQ-032 Zero operand: a = 0, b = 4'h9 -> product = 0 with the full 4-cycle latency.
